// File: rtl/amber48_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : amber48_uart_rx
// Description : 8N1 UART receiver with a ready/valid byte output, frame-error
//               and overrun pulses. Define AMBER48_UART_RX_MAJORITY_EN to take
//               every bit sample as a 2-of-3 majority vote.
// Revision    : 1.0 - initial release
// ============================================================================
module amber48_uart_rx #(
    parameter int CLOCK_FREQ_HZ = 27_000_000,
    parameter int BAUD_RATE     = 115_200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CLKS_PER_BIT = (CLOCK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $fatal(1, "amber48_uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    logic [1:0]       r_sync;
    logic             w_rx_s;
    logic             w_sample;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;

    // Synchronizer resets high so a reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_i};
        end
    end

    assign w_rx_s = r_sync[1];

`ifdef AMBER48_UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // r_hist[0]/r_hist[1] hold rx_s from one and two cycles back.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) |
                      (r_hist[1] & w_rx_s)    |
                      (r_hist[0] & w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= c_cnt_zero;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;

            // A byte landing in the stop branch below overrides this clear.
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= c_cnt_half;
                    end
                end

                S_START: begin
                    if (r_cnt == c_cnt_zero) begin
                        if (!w_sample) begin
                            r_state <= S_DATA;
                            r_cnt   <= c_cnt_full;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_cnt_zero) begin
                        r_shift[r_idx] <= w_sample;
                        r_cnt          <= c_cnt_full;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                S_STOP: begin
                    if (r_cnt == c_cnt_zero) begin
                        if (w_sample) begin
                            data_o    <= r_shift;
                            valid_o   <= 1'b1;
                            overrun_o <= valid_o && !ready_i;
                            r_state   <= S_IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                S_WAIT_IDLE: begin
                    // A break holds the line low; wait for it to end.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/amber48_uart_rx.md
AMBER48_UART_RX -- requirements
Module: amber48_uart_rx

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ_HZ, default 27_000_000, meaning the clk_i frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port data_o, output, 8 bits: received byte, stable while valid_o is high.
REQ-007 The block SHALL have port valid_o, output, 1 bit: data_o holds an unconsumed byte.
REQ-008 The block SHALL have port ready_i, input, 1 bit: the consumer accepts data_o when valid_o && ready_i.
REQ-009 The block SHALL have port frame_err_o, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-010 The block SHALL have port overrun_o, output, 1 bit: one-cycle pulse when an unconsumed byte is overwritten.

Function
REQ-011 The block SHALL define CLKS_PER_BIT = (CLOCK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE and HALF_BIT = CLKS_PER_BIT/2; CLKS_PER_BIT < 4 SHALL raise $fatal at elaboration.
REQ-012 The block SHALL pass rx_i through a 2-flop synchronizer (reset value 1) to form rx_s; all decisions use rx_s only.
REQ-013 The block SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_IDLE, with a down-counter sized $clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-014 IDLE: on rx_s==0 -> START, counter = HALF_BIT-1.
REQ-015 START: counter==0 and rx_s==0 -> DATA, counter = CLKS_PER_BIT-1, index = 0; counter==0 and rx_s==1 -> IDLE (glitch rejected, no outputs); otherwise decrement.
REQ-016 DATA: at counter==0 the sampled bit SHALL be shifted into the shift register at bit[index] (LSB first) and counter reloaded; at index 7 -> STOP instead of incrementing.
REQ-017 STOP: at counter==0 with a high sample, the shift register SHALL load into data_o, valid_o SHALL be set on the next edge, and the FSM -> IDLE.
REQ-018 STOP: at counter==0 with a low sample, the block SHALL discard the byte, pulse frame_err_o for one cycle and go to WAIT_IDLE; data_o and valid_o SHALL stay unchanged.
REQ-019 WAIT_IDLE: the FSM SHALL remain until rx_s==1, then -> IDLE (no start detection during break).
REQ-020 valid_o SHALL clear on the edge after valid_o && ready_i, unless a new byte loads in that same cycle.
REQ-021 A byte completes while valid_o=1 and ready_i=0: data_o SHALL take the new byte, valid_o SHALL stay 1, and overrun_o SHALL pulse for one cycle.
REQ-022 A byte completes in the same cycle as valid_o && ready_i: the new byte SHALL load, valid_o SHALL stay 1, and there SHALL be no overrun.
REQ-023 Total latency: valid_o SHALL rise exactly one clk_i after the stop-bit sampling edge.

Reset
REQ-024 While rst_i=1 at a clk_i edge, the block SHALL return the FSM to IDLE and set counter and index to 0, the synchronizer flops to 1, data_o to 0x00, and valid_o, frame_err_o and overrun_o to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no byte, error or overrun reported; after release, reception SHALL resume at the next falling edge of rx_s.

Configuration
REQ-026 With macro AMBER48_UART_RX_MAJORITY_EN defined, each START/DATA/STOP sample SHALL be the 2-of-3 majority of rx_s at counter values 2, 1 and 0 of that bit.
REQ-027 Without AMBER48_UART_RX_MAJORITY_EN, each sample SHALL be the single value of rx_s at counter==0; the history register SHALL be absent.

Verification (CLOCK_FREQ_HZ=460_800, BAUD_RATE=115_200 -> CLKS_PER_BIT=4, HALF_BIT=2)
REQ-028 The bench SHALL drive byte 0xA5 (8N1) with ready_i=1 -> valid_o pulses for 1 cycle with data_o=0xA5, frame_err_o=0, overrun_o=0.
REQ-029 The bench SHALL drive a 1-clk low glitch on idle rx_i -> no valid_o or frame_err_o; the next byte 0x3C is then received correctly.
REQ-030 The bench SHALL drive byte 0x55 with the stop bit low, then hold rx_i low for 20 cycles, then high, then send 0x0F -> frame_err_o pulses once, valid_o stays 0 during the break, then data_o=0x0F.
REQ-031 The bench SHALL hold ready_i=0 and send 0x11 then 0x22 -> overrun_o pulses once at the second completion, data_o=0x22, valid_o=1.
REQ-032 The bench SHALL assert rst_i for 1 cycle during data bit 3 of 0xFF, then send 0x81 -> only 0x81 is reported.
REQ-033 With AMBER48_UART_RX_MAJORITY_EN defined, the bench SHALL send 0x00 with a 1-clk high glitch at the middle of each data bit -> data_o=0x00; without the macro, it SHALL check the corrupted value instead.
